// File: rtl/alu_mul_sequencer.sv
// Shift-add multiplier producing the low WIDTH bits of a product.
// While busy it owns the ALU inputs and uses the external ALU as its adder.
module alu_mul_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6     // 2**CNT_W must exceed WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic [WIDTH-1:0] alu_operand_A,
    output logic [WIDTH-1:0] alu_operand_B,
    output logic [2:0]       alu_operation,
    input  logic [WIDTH-1:0] alu_result
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0]       OP_ADD   = 3'b010;
    localparam logic [2:0]       OP_NONE  = 3'b000;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0] mplier_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [2:0]       alu_op_reg;

    logic [WIDTH-1:0] mplier_shr;
    logic             run_last;

    // Stop as soon as no multiplier bits remain, so short multipliers finish early.
    assign mplier_shr = mplier_reg >> 1;
    assign run_last   = (mplier_shr == '0) || (cnt_reg == LAST_CNT);

    assign busy          = busy_reg;
    assign done          = done_reg;
    assign product       = acc_reg;
    assign alu_operand_A = acc_reg;
    assign alu_operand_B = mcand_reg;
    assign alu_operation = alu_op_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            cnt_reg    <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            alu_op_reg <= OP_NONE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        acc_reg    <= '0;
                        mcand_reg  <= multiplicand;
                        mplier_reg <= multiplier;
                        cnt_reg    <= '0;
                        busy_reg   <= 1'b1;
                        if (multiplier == '0) begin
                            state_reg  <= ST_DONE;
                            done_reg   <= 1'b1;
                            alu_op_reg <= OP_NONE;
                        end else begin
                            state_reg  <= ST_RUN;
                            alu_op_reg <= OP_ADD;
                        end
                    end
                end

                ST_RUN: begin
                    // The ALU sums acc + mcand combinationally; keep it only for set bits.
                    if (mplier_reg[0]) begin
                        acc_reg <= alu_result;
                    end
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_shr;
                    cnt_reg    <= cnt_reg + 1'b1;
                    if (run_last) begin
                        state_reg  <= ST_DONE;
                        done_reg   <= 1'b1;
                        alu_op_reg <= OP_NONE;
                    end
                end

                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end

                default: begin
                    state_reg  <= ST_IDLE;
                    busy_reg   <= 1'b0;
                    done_reg   <= 1'b0;
                    alu_op_reg <= OP_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench for alu_mul_sequencer: vector table, corner sequences
// and random operands against an arithmetic reference, with a local ALU model.
module tb_alu_mul_sequencer;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0] multiplier;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] product;
    logic [WIDTH-1:0] alu_operand_A;
    logic [WIDTH-1:0] alu_operand_B;
    logic [2:0]       alu_operation;
    logic [WIDTH-1:0] alu_result;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_mul_sequencer #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .multiplicand  (multiplicand),
        .multiplier    (multiplier),
        .busy          (busy),
        .done          (done),
        .product       (product),
        .alu_operand_A (alu_operand_A),
        .alu_operand_B (alu_operand_B),
        .alu_operation (alu_operation),
        .alu_result    (alu_result)
    );

    // External ALU stand-in: only the add code yields a sum.
    always_comb begin
        alu_result = '0;
        case (alu_operation)
            3'b010:  alu_result = alu_operand_A + alu_operand_B;
            3'b000:  alu_result = alu_operand_A & alu_operand_B;
            default: alu_result = alu_operand_A ^ alu_operand_B;
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int ref_k(input logic [WIDTH-1:0] m);
        int k = 0;
        for (int i = 0; i < WIDTH; i++) if (m[i]) k = i + 1;
        return k;
    endfunction

    // Launch one op from IDLE; returns cycles from accept edge to done, and RUN-op cycles.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          output int lat, output int nop, output logic [WIDTH-1:0] prod);
        @(negedge clk);
        start = 1'b1; multiplicand = a; multiplier = b;
        @(negedge clk);
        start = 1'b0; multiplicand = $urandom; multiplier = $urandom;
        lat = 1; nop = 0;
        while (!done && lat < 100) begin
            if (alu_operation == 3'b010) nop++;
            @(negedge clk);
            lat++;
        end
        prod = product;
    endtask

    task automatic op_and_check(input string tag, input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b);
        int lat, nop, k;
        logic [WIDTH-1:0] prod, exp_p;
        logic [63:0] full;
        full  = 64'(a) * 64'(b);
        exp_p = full[WIDTH-1:0];
        k     = ref_k(b);
        run_op(a, b, lat, nop, prod);
        check({tag, " latency"}, 64'(lat), 64'(k + 1));
        check({tag, " add_cycles"}, 64'(nop), 64'(k));
        check({tag, " product"}, 64'(prod), 64'(exp_p));
        check({tag, " busy_in_done"}, 64'(busy), 64'(1));
        @(negedge clk);
        check({tag, " idle_after"}, {62'd0, busy, done}, 64'd0);
        check({tag, " held"}, 64'(product), 64'(exp_p));
        $display("op %s: %08h * %08h -> %08h lat=%0d", tag, a, b, prod, lat);
    endtask

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] p;
        int               k;
    } vec_t;

    initial begin
        vec_t vecs[6];
        int lat, nop;
        logic [WIDTH-1:0] prod;
        logic [WIDTH-1:0] opa[3];
        bit saw_done;

        vecs[0] = '{32'd6,        32'd7,        32'd42,         3};
        vecs[1] = '{32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1,   3};
        vecs[2] = '{32'd1,        32'h80000000, 32'h80000000,  32};
        vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001,  32};
        vecs[4] = '{32'h1234,     32'd0,        32'd0,          0};
        vecs[5] = '{32'h00010000, 32'h00010000, 32'd0,         17};

        rst_n = 1'b0; start = 1'b0; multiplicand = '0; multiplier = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("reset busy_done", {62'd0, busy, done}, 64'd0);
        check("reset product", 64'(product), 64'd0);
        check("reset alu_op", 64'(alu_operation), 64'd0);
        check("reset operands", {alu_operand_A, alu_operand_B}, 64'd0);

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, lat, nop, prod);
            check($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].k + 1));
            check($sformatf("vec%0d add_cycles", i), 64'(nop), 64'(vecs[i].k));
            check($sformatf("vec%0d product", i), 64'(prod), 64'(vecs[i].p));
            @(negedge clk);
            check($sformatf("vec%0d idle_after", i), {62'd0, busy, done}, 64'd0);
            $display("vec%0d: %08h * %08h -> %08h lat=%0d", i, vecs[i].a, vecs[i].b, prod, lat);
        end

        // -3*5: accumulator must hold through the cycle where the multiplier bit is 0.
        @(negedge clk);
        start = 1'b1; multiplicand = 32'hFFFFFFFD; multiplier = 32'd5;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            opa[c] = alu_operand_A;
        end
        check("neg3x5 acc c1", 64'(opa[0]), 64'd0);
        check("neg3x5 acc c2", 64'(opa[1]), 64'(32'hFFFFFFFD));
        check("neg3x5 acc c3", 64'(opa[2]), 64'(32'hFFFFFFFD));
        @(negedge clk);
        check("neg3x5 done", 64'(done), 64'd1);
        check("neg3x5 product", 64'(product), 64'(32'hFFFFFFF1));
        $display("seq neg3x5: acc %08h %08h %08h product %08h", opa[0], opa[1], opa[2], product);
        @(negedge clk);

        // start mid-RUN is ignored; start held through DONE is accepted on the following IDLE edge.
        @(negedge clk);
        start = 1'b1; multiplicand = 32'd6; multiplier = 32'd7;
        @(negedge clk);
        multiplicand = 32'd100; multiplier = 32'hFF;
        @(negedge clk);
        start = 1'b0;
        lat = 2;
        while (!done && lat < 100) begin @(negedge clk); lat++; end
        check("ignore_start latency", 64'(lat), 64'd4);
        check("ignore_start product", 64'(product), 64'd42);
        $display("seq ignore_start: product %0d lat=%0d", product, lat);
        start = 1'b1; multiplicand = 32'd9; multiplier = 32'd3;
        @(negedge clk);
        check("done_start ignored", 64'(busy), 64'd0);
        @(negedge clk);
        start = 1'b0;
        check("b2b accepted", {62'd0, busy, done}, 64'd2);
        lat = 1;
        while (!done && lat < 100) begin @(negedge clk); lat++; end
        check("b2b latency", 64'(lat), 64'd3);
        check("b2b product", 64'(product), 64'd27);
        $display("seq back_to_back: product %0d lat=%0d", product, lat);
        @(negedge clk);

        // Reset mid-RUN.
        @(negedge clk);
        start = 1'b1; multiplicand = 32'd3; multiplier = 32'hFF;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst busy_done", {62'd0, busy, done}, 64'd0);
        check("midrst product", 64'(product), 64'd0);
        check("midrst alu_op", 64'(alu_operation), 64'd0);
        saw_done = 1'b0;
        repeat (12) begin @(negedge clk); if (done || busy) saw_done = 1'b1; end
        check("midrst quiet", 64'(saw_done), 64'd0);
        $display("seq mid_reset: busy=%0d done=%0d product=%08h", busy, done, product);

        for (int r = 0; r < 30; r++) begin
            logic [WIDTH-1:0] a, b;
            a = $urandom;
            b = (r % 7 == 0) ? '0 : ($urandom >> $urandom_range(0, 31));
            op_and_check($sformatf("rnd%0d", r), a, b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
- Multi-cycle shift-add multiplier that acts as the initiator side of the shared combinational ALU interface.
- It drives operand_A, operand_B and a 3-bit operation code to an external ALU, and consumes that ALU's result in the same cycle.
- It produces the low WIDTH bits of a product (RISC-V MUL semantics; signed and unsigned low halves are identical).
- It sits beside the ALU in the execute stage and owns the ALU inputs while busy.

Parameters:
WIDTH, 32, operand/product width; must match the external ALU data width.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start  input  1  request; sampled only in IDLE
multiplicand  input  WIDTH  operand, latched on accepted start
multiplier  input  WIDTH  operand, latched on accepted start
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse; product valid
product  output  WIDTH  low WIDTH bits of multiplicand*multiplier; held until next accepted start
alu_operand_A  output  WIDTH  to ALU operand_A; equals the accumulator register
alu_operand_B  output  WIDTH  to ALU operand_B; equals the shifted-multiplicand register
alu_operation  output  3  to ALU operation; 3'b010 (add) in RUN, 3'b000 otherwise
alu_result  input  WIDTH  from ALU result (combinational, same cycle)

Behaviour:
- Reset (rst_n low at a clock edge) returns the block to IDLE from any state, including mid-RUN. It clears acc, mcand, mplier, the counter, busy, done and product to 0; alu_operation becomes 3'b000.
- Registers: acc (WIDTH), mcand (WIDTH), mplier (WIDTH), cnt (CNT_W). product is driven from acc.
- States: IDLE, RUN, DONE. busy = (state != IDLE). done = (state == DONE).
- IDLE, start=1 at edge T:
  - acc <= 0; mcand <= multiplicand; mplier <= multiplier; cnt <= 0.
  - If multiplier == 0, next state is DONE (done high in cycle T+1, product 0). Otherwise next state is RUN.
- IDLE, start=0: state, acc and product hold.
- RUN, each cycle:
  - alu_operation = 3'b010; alu_operand_A = acc; alu_operand_B = mcand.
  - If mplier[0], acc <= alu_result; otherwise acc holds.
  - mcand <= mcand << 1 (zero fill, MSB discarded); mplier <= mplier >> 1 (logical); cnt <= cnt + 1.
  - Exit to DONE when (mplier >> 1) == 0 or cnt == WIDTH-1; otherwise stay in RUN.
- RUN cycle count k = index of the highest set bit of multiplier + 1 (1..WIDTH). With start accepted at edge T, done is high in cycle T+k+1.
- DONE: lasts exactly one cycle, then IDLE. start during DONE is ignored; start in the following IDLE cycle is accepted (back-to-back rate is one op per k+2 cycles).
- start while busy is ignored; operand inputs are not sampled after acceptance.
- Arithmetic is modulo 2^WIDTH. Overflow is discarded silently and no flags are produced. ALU is_zero/is_negative are not consumed.
- alu_operation stays 3'b000 in IDLE and DONE, so the ALU is free for other users there. Arbitration is outside this block.

Test Plan:
- multiplicand=6, multiplier=7, start at T -> RUN for 3 cycles; done=1 at T+4; product=42; alu_operation=3'b010 only in T+1..T+3.
- multiplicand=0xFFFFFFFD (-3), multiplier=5 -> k=3; done at T+4; product=0xFFFFFFF1 (-15); acc unchanged in the cycle where mplier[0]=0.
- multiplicand=1, multiplier=0x80000000 -> k=32; done at T+33; product=0x80000000. Also multiplicand=0xFFFFFFFF, multiplier=0xFFFFFFFF -> product=0x00000001 after 32 RUN cycles.
- multiplier=0, multiplicand=0x1234 -> done at T+1; product=0; alu_operation never 3'b010.
- Second start pulsed during RUN with different operands -> ignored; product is from the first operands; a start on the cycle after done is accepted.
- rst_n low for one edge mid-RUN (multiplier 0xFF) -> next cycle busy=0, done=0, product=0, alu_operation=3'b000; no done pulse follows.
